// File: rtl/led_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_sb_pkg
// Purpose  : Shared types and constants for the system-bus LED controller:
//            LED operating mode encoding, register byte addresses and the
//            PWM counter width.
// Revision : 1.0 - initial release
// ============================================================================
package led_sb_pkg;

    typedef enum logic [1:0] {
        STATIC = 2'd0,
        BLINK  = 2'd1,
        PWM    = 2'd2
    } led_mode_e;

    localparam logic [31:0] LED_VALUE_ADDR = 32'h0000_0000;
    localparam logic [31:0] LED_MODE_ADDR  = 32'h0000_0004;
    localparam logic [31:0] LED_BLINK_ADDR = 32'h0000_0008;
    localparam logic [31:0] LED_DUTY_ADDR  = 32'h0000_000C;
    localparam logic [31:0] LED_RST_ADDR   = 32'h0000_0024;

    localparam int unsigned PWM_W = 8;

endpackage
`default_nettype wire

// File: rtl/led_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_gen
// Purpose  : Free-running PWM counter with duty compare. The counter is held
//            at zero while disabled or cleared, so a fresh enable always
//            starts in the on-portion of the cycle.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            i_en   - counter runs while high
//            i_clr  - synchronous counter clear (highest priority)
//            i_duty - on-time in counter steps (0 = always off)
//            o_on   - high while counter < duty
// Revision : 1.0 - initial release
// ============================================================================
module led_pwm_gen
    import led_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [PWM_W-1:0] i_duty,
    output logic             o_on
);

    logic [PWM_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;   // natural wrap 255 -> 0
        end
    end

    assign o_on = (r_cnt < i_duty);

endmodule
`default_nettype wire

// File: rtl/led_sb_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_sb_multi_ctrl
// Purpose  : System-bus LED controller with STATIC, BLINK and optional PWM
//            modes. Registers: VALUE (0x00), MODE (0x04), BLINK_HALF (0x08),
//            PWM_DUTY (0x0C), SOFT_RST (0x24, write-only). Invalid writes are
//            dropped without side effects.
// Config   : define LED_SB_PWM_EN to build PWM mode, PWM_DUTY and the PWM
//            generator; otherwise MODE=2 is rejected and 0x0C reads as 0.
// Ports    : clk_i, rst_ni (async active-low), req_i, write_enable_i,
//            addr_i[31:0], write_data_i[31:0], read_data_o[31:0] (registered,
//            1-cycle latency), led_o[N_LEDS-1:0] (from registered state only).
// Revision : 1.0 - initial release
// ============================================================================
module led_sb_multi_ctrl
    import led_sb_pkg::*;
#(
    parameter int unsigned N_LEDS        = 16,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned BLINK_DEFAULT = 10000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              write_enable_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       write_data_i,
    output logic [31:0]       read_data_o,
    output logic [N_LEDS-1:0] led_o
);

    // Legal-value masks: a write is valid only if no bit above the field is set.
    localparam logic [31:0] c_value_mask =
        (N_LEDS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N_LEDS) - 32'd1);
    localparam logic [31:0] c_blink_mask =
        (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);
    localparam logic [CNT_W-1:0] c_blink_rst = CNT_W'(BLINK_DEFAULT);

    logic [N_LEDS-1:0] r_value;
    led_mode_e         r_mode;
    logic [CNT_W-1:0]  r_blink_half;
    logic [CNT_W-1:0]  r_blink_cnt;
    logic              r_phase;
    logic [31:0]       r_read_data;

    logic              w_wr;
    logic              w_rd;
    logic              w_value_wr;
    logic              w_mode_wr;
    logic              w_blink_wr;
    logic              w_soft_rst;
    logic              w_cnt_clr;
    logic              w_pwm_on;
    logic [31:0]       w_rd_val;

    assign w_wr = req_i &  write_enable_i;
    assign w_rd = req_i & ~write_enable_i;

    assign w_value_wr = w_wr && (addr_i == LED_VALUE_ADDR)
                        && ((write_data_i & ~c_value_mask) == 32'd0);
`ifdef LED_SB_PWM_EN
    assign w_mode_wr  = w_wr && (addr_i == LED_MODE_ADDR) && (write_data_i <= 32'd2);
`else
    assign w_mode_wr  = w_wr && (addr_i == LED_MODE_ADDR) && (write_data_i <= 32'd1);
`endif
    assign w_blink_wr = w_wr && (addr_i == LED_BLINK_ADDR) && (write_data_i != 32'd0)
                        && ((write_data_i & ~c_blink_mask) == 32'd0);
    assign w_soft_rst = w_wr && (addr_i == LED_RST_ADDR) && (write_data_i == 32'd1);

    // Any mode or period change restarts both time bases in the on-phase.
    assign w_cnt_clr  = w_mode_wr | w_blink_wr | w_soft_rst;

`ifdef LED_SB_PWM_EN
    logic [PWM_W-1:0] r_duty;
    logic             w_duty_wr;

    assign w_duty_wr = w_wr && (addr_i == LED_DUTY_ADDR) && (write_data_i < 32'd256);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_duty <= '0;
        end else if (w_soft_rst) begin
            r_duty <= '0;
        end else if (w_duty_wr) begin
            r_duty <= write_data_i[PWM_W-1:0];
        end
    end

    led_pwm_gen u_pwm_gen (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .i_en   (r_mode == PWM),
        .i_clr  (w_cnt_clr),
        .i_duty (r_duty),
        .o_on   (w_pwm_on)
    );
`else
    assign w_pwm_on = 1'b0;
`endif

    always_comb begin
        w_rd_val = 32'd0;
        case (addr_i)
            LED_VALUE_ADDR: w_rd_val = 32'(r_value);
            LED_MODE_ADDR:  w_rd_val = 32'(r_mode);
            LED_BLINK_ADDR: w_rd_val = 32'(r_blink_half);
`ifdef LED_SB_PWM_EN
            LED_DUTY_ADDR:  w_rd_val = 32'(r_duty);
`endif
            default:        w_rd_val = 32'd0;
        endcase
    end

    // Register file and read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_value      <= '0;
            r_mode       <= STATIC;
            r_blink_half <= c_blink_rst;
            r_read_data  <= '0;
        end else if (w_soft_rst) begin
            r_value      <= '0;
            r_mode       <= STATIC;
            r_blink_half <= c_blink_rst;
            r_read_data  <= '0;
        end else begin
            if (w_value_wr) r_value      <= N_LEDS'(write_data_i);
            if (w_mode_wr)  r_mode       <= led_mode_e'(write_data_i[1:0]);
            if (w_blink_wr) r_blink_half <= CNT_W'(write_data_i);
            if (w_rd)       r_read_data  <= w_rd_val;
        end
    end

    // Blink time base: counts 0..BLINK_HALF-1, toggling phase at each wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_cnt_clr || (r_mode != BLINK)) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == (r_blink_half - CNT_W'(1))) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        led_o = '0;
        case (r_mode)
            STATIC:  led_o = r_value;
            BLINK:   led_o = r_phase  ? '0 : r_value;
            PWM:     led_o = w_pwm_on ? r_value : '0;
            default: led_o = '0;
        endcase
    end

    assign read_data_o = r_read_data;

endmodule
`default_nettype wire

// File: doc/led_sb_multi_ctrl.md
LED_SB_MULTI_CTRL -- requirements
Module: led_sb_multi_ctrl

Interface
REQ-001 Parameter N_LEDS, default 16: number of LED outputs, legal range 1..32.
REQ-002 Parameter CNT_W, default 32: width of the blink period register and blink counter.
REQ-003 Parameter BLINK_DEFAULT, default 10000000: reset value of the blink half-period register, in clk_i cycles.
REQ-004 Port clk_i, input, 1: the only clock; all state changes on its rising edge.
REQ-005 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 Port req_i, input, 1: system-bus request strobe.
REQ-007 Port write_enable_i, input, 1: 1 means write, 0 means read; sampled only while req_i is 1.
REQ-008 Port addr_i, input, 32: byte address of the register being accessed.
REQ-009 Port write_data_i, input, 32: data for a write access.
REQ-010 Port read_data_o, output, 32: registered read data.
REQ-011 Port led_o, output, N_LEDS: LED drive outputs.

Function
REQ-012 Register map:
  - 0x00 VALUE: N_LEDS bits, the LED pattern.
  - 0x04 MODE: 2 bits; 0 = STATIC, 1 = BLINK, 2 = PWM.
  - 0x08 BLINK_HALF: CNT_W bits.
  - 0x0C PWM_DUTY: 8 bits.
  - 0x24 SOFT_RST: write-only.
REQ-013 Write accepted only when req_i=1 and write_enable_i=1 and the data is valid; takes effect at that clock edge.
REQ-014 Validity rules; an invalid write is ignored and all state is unchanged:
  - VALUE: write_data_i < 2^N_LEDS.
  - MODE: write_data_i in {0, 1, 2}.
  - BLINK_HALF: write_data_i nonzero and < 2^CNT_W.
  - PWM_DUTY: write_data_i < 256.
  - SOFT_RST: write_data_i == 1.
REQ-015 Read (req_i=1, write_enable_i=0) loads read_data_o on the next edge with the zero-extended register; 1-cycle latency; read_data_o holds until the next read.
REQ-016 A read of an unmapped address or of SOFT_RST loads 0 into read_data_o.
REQ-017 STATIC mode: led_o = VALUE.
REQ-018 BLINK mode:
  - Blink counter counts 0..BLINK_HALF-1, wraps to 0 and toggles the phase bit.
  - led_o = VALUE while phase = 0, else all zeros.
  - Full period = 2*BLINK_HALF cycles.
REQ-019 PWM mode:
  - 8-bit PWM counter free-runs 0..255 and wraps.
  - led_o = VALUE while pwm_cnt < PWM_DUTY, else zeros.
  - Duty 0 means always off; duty 255 means on 255 of 256 cycles.
REQ-020 An accepted MODE or BLINK_HALF write clears the blink counter, phase and PWM counter on the same edge, so the new mode starts in the on-phase.
REQ-021 Counters are held at 0 while not in their own mode.
REQ-022 led_o is combinational from registered state only, never from bus inputs.
REQ-023 An accepted VALUE write during BLINK or PWM mode changes the pattern only; counters and phase are unaffected.
REQ-024 An accepted SOFT_RST write returns every register, counter, phase and read_data_o to its reset value at that edge.

Reset
REQ-025 Reset values (rst_ni=0, asynchronous) are:
  - VALUE = 0, MODE = STATIC, BLINK_HALF = BLINK_DEFAULT, PWM_DUTY = 0.
  - Counters = 0, phase = 0.
  - read_data_o = 0, hence led_o = 0.
REQ-026 Deassertion of rst_ni is expected synchronous to clk_i; the first access is accepted on the first edge with rst_ni=1.

Configuration
REQ-027 Macro LED_SB_PWM_EN: when defined, PWM mode, the PWM_DUTY register and the PWM counter are present.
REQ-028 When LED_SB_PWM_EN is undefined:
  - A MODE write of 2 is invalid and ignored.
  - PWM_DUTY writes are ignored and reads of 0x0C return 0.
  - No PWM logic is synthesised.

Structure
REQ-029 Package led_sb_pkg holds:
  - enum led_mode_e with values STATIC, BLINK, PWM.
  - Address constants LED_VALUE_ADDR, LED_MODE_ADDR, LED_BLINK_ADDR, LED_DUTY_ADDR, LED_RST_ADDR.
  - PWM_W = 8.
REQ-030 Sub-module led_pwm_gen (PWM counter plus compare, enable and clear inputs, 1-bit on output) is instantiated only under LED_SB_PWM_EN.

Verification
REQ-031 Reset and read latency: after reset, write VALUE=0xA5A5 then read 0x00 -> read_data_o=0x0000A5A5 one cycle after the read request; led_o=0xA5A5.
REQ-032 Invalid writes: write VALUE=0x10000 and MODE=3 -> VALUE, MODE and led_o unchanged.
REQ-033 Blink timing: BLINK_HALF=4, VALUE=0x00FF, MODE=1 -> led_o=0x00FF for 4 cycles, then 0 for 4 cycles, repeating.
REQ-034 PWM duty: with LED_SB_PWM_EN, DUTY=64, MODE=2, VALUE=0xFFFF -> led_o=0xFFFF for exactly 64 of every 256 cycles; DUTY=0 gives constant 0.
REQ-035 Reset mid-operation: SOFT_RST write of 1 during BLINK off-phase -> next cycle MODE=0, VALUE=0, BLINK_HALF=BLINK_DEFAULT, led_o=0; rst_ni pulse mid-cycle clears the same state immediately.
REQ-036 Build without LED_SB_PWM_EN: MODE=2 write ignored; read of 0x0C returns 0.
